// File: rtl/pcreg_fetch_pkg.sv
// Shared types and constants for the fetch-stage PC register / fetch sequencer.
// Holds the reset PC, the sequencer state encoding and the fetch/decode bundle.
package pcreg_fetch_pkg;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    VALID   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        exc_misalign;
  } fetch_data_t;

  function automatic logic is_aligned(input logic [63:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pcreg_fetch.sv
// PC register and single-outstanding instruction fetch sequencer.
// Issues one bus request at a time and presents the result to decode.
module pcreg_fetch
  import pcreg_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pred_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_raw_instr,
  output logic        f_exc_misalign,
  output logic [63:0] pcplus4
);

  fetch_state_t state_reg;
  logic [63:0]  pc_reg;
  logic [63:0]  req_addr_reg;
  fetch_data_t  f_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg          <= FETCH;
      pc_reg             <= RESET_PC;
      req_addr_reg       <= RESET_PC;
      f_reg.valid        <= 1'b0;
      f_reg.pc           <= RESET_PC;
      f_reg.raw_instr    <= 32'h0;
      f_reg.exc_misalign <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (!is_aligned(pc_reg)) begin
            // No bus request was issued, so a redirect simply replaces the target.
            if (redirect_valid) begin
              pc_reg       <= redirect_pc;
              req_addr_reg <= redirect_pc;
            end else begin
              state_reg          <= VALID;
              f_reg.valid        <= 1'b1;
              f_reg.pc           <= pc_reg;
              f_reg.raw_instr    <= 32'h0;
              f_reg.exc_misalign <= 1'b1;
            end
          end else if (iresp_data_ok) begin
            if (redirect_valid) begin
              pc_reg       <= redirect_pc;
              req_addr_reg <= redirect_pc;
            end else begin
              state_reg          <= VALID;
              f_reg.valid        <= 1'b1;
              f_reg.pc           <= req_addr_reg;
              f_reg.raw_instr    <= iresp_data;
              f_reg.exc_misalign <= 1'b0;
            end
          end else if (redirect_valid) begin
            // Request still in flight: keep its address on the bus and drop its data later.
            pc_reg    <= redirect_pc;
            state_reg <= DISCARD;
          end
        end

        VALID: begin
          if (redirect_valid) begin
            pc_reg       <= redirect_pc;
            req_addr_reg <= redirect_pc;
            state_reg    <= FETCH;
            f_reg.valid  <= 1'b0;
          end else if (!stall) begin
            pc_reg       <= pred_pc;
            req_addr_reg <= pred_pc;
            state_reg    <= FETCH;
            f_reg.valid  <= 1'b0;
          end
        end

        DISCARD: begin
          if (redirect_valid) begin
            pc_reg <= redirect_pc;
          end
          if (iresp_data_ok) begin
            req_addr_reg <= redirect_valid ? redirect_pc : pc_reg;
            state_reg    <= FETCH;
          end
        end

        default: begin
          state_reg   <= FETCH;
          f_reg.valid <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign ireq_valid = reset && (((state_reg == FETCH) && is_aligned(pc_reg)) ||
                                (state_reg == DISCARD));
  assign ireq_addr      = req_addr_reg;
  assign f_valid        = reset && f_reg.valid;
  assign f_pc           = f_reg.pc;
  assign f_raw_instr    = f_reg.raw_instr;
  assign f_exc_misalign = f_reg.exc_misalign;
  assign pcplus4        = f_reg.pc + 64'd4;

endmodule

// File: tb/tb_pcreg_fetch.sv
// Bench for pcreg_fetch: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_pcreg_fetch;

  localparam logic [63:0] RST = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pred_pc = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_raw_instr;
  logic        f_exc_misalign;
  logic [63:0] pcplus4;

  int checks = 0;
  int errors = 0;

  pcreg_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .pred_pc        (pred_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_raw_instr    (f_raw_instr),
    .f_exc_misalign (f_exc_misalign),
    .pcplus4        (pcplus4)
  );

  always #5 clk = ~clk;

  // Model: next PC, address of the outstanding request, whether an instruction
  // is being presented, whether the in-flight response must be dropped.
  bit          m_present = 1'b0;
  bit          m_drop = 1'b0;
  logic [63:0] m_pc = RST;
  logic [63:0] m_req = RST;
  logic [63:0] m_fpc = RST;
  logic [31:0] m_instr = '0;
  bit          m_exc = 1'b0;

  function automatic bit exp_ireq(input bit r);
    return r && !m_present && (m_drop || (m_pc[1:0] == 2'b00));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit rv, input logic [63:0] rpc, input bit st,
                            input logic [63:0] pp, input bit ok, input logic [31:0] d);
    if (!r) begin
      m_pc = RST; m_req = RST; m_present = 0; m_drop = 0;
      m_fpc = RST; m_instr = '0; m_exc = 0;
    end else if (m_present) begin
      if (rv || !st) begin
        m_present = 0;
        m_pc = rv ? rpc : pp;
        m_req = m_pc;
      end
    end else if (m_drop) begin
      if (rv) m_pc = rpc;
      if (ok) begin
        m_req = m_pc;
        m_drop = 0;
      end
    end else if (m_pc[1:0] != 2'b00) begin
      if (rv) begin
        m_pc = rpc; m_req = rpc;
      end else begin
        m_present = 1; m_fpc = m_pc; m_instr = '0; m_exc = 1;
      end
    end else if (ok) begin
      if (rv) begin
        m_pc = rpc; m_req = rpc;
      end else begin
        m_present = 1; m_fpc = m_req; m_instr = d; m_exc = 0;
      end
    end else if (rv) begin
      m_pc = rpc;
      m_drop = 1;
    end
  endtask

  task automatic compare_all();
    chk("ireq_valid", 64'(ireq_valid), 64'(exp_ireq(reset)));
    if (exp_ireq(reset)) chk("ireq_addr", ireq_addr, m_req);
    chk("f_valid", 64'(f_valid), 64'(reset && m_present));
    chk("f_pc", f_pc, m_fpc);
    chk("f_raw_instr", 64'(f_raw_instr), 64'(m_instr));
    chk("f_exc_misalign", 64'(f_exc_misalign), 64'(m_exc));
    chk("pcplus4", pcplus4, m_fpc + 64'd4);
  endtask

  // Drive one cycle of inputs at a falling edge, advance the model, then
  // compare at the next falling edge.
  task automatic cycle(input bit r, input bit rv, input logic [63:0] rpc, input bit st,
                       input logic [63:0] pp, input bit ok, input logic [31:0] d);
    reset = r; redirect_valid = rv; redirect_pc = rpc; stall = st;
    pred_pc = pp; iresp_data_ok = ok; iresp_data = d;
    model_step(r, rv, rpc, st, pp, ok, d);
    @(negedge clk);
    compare_all();
    $display("cyc rst=%0b rv=%0b rpc=%h st=%0b ok=%0b | ireq=%0b addr=%h fv=%0b fpc=%h instr=%h exc=%0b",
             r, rv, rpc, st, ok, ireq_valid, ireq_addr, f_valid, f_pc, f_raw_instr, f_exc_misalign);
  endtask

  function automatic logic [63:0] rand_pc();
    int k = $urandom_range(0, 99);
    if (k < 70) return 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
    else if (k < 85) return 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4
                            + 64'($urandom_range(1, 3));
    else return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
  endfunction

  initial begin
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0, '0, 0, '0);
    chk("lit_rst_ireq", 64'(ireq_valid), 64'd0);
    chk("lit_rst_fvalid", 64'(f_valid), 64'd0);
    chk("lit_rst_fpc", f_pc, RST);
    chk("lit_rst_instr", 64'(f_raw_instr), 64'd0);

    // Release; response on the third cycle
    cycle(1, 0, '0, 0, '0, 0, '0);
    chk("lit_req0_addr", ireq_addr, 64'h8000_0000);
    cycle(1, 0, '0, 0, '0, 0, '0);
    cycle(1, 0, '0, 0, '0, 1, 32'h0000_0013);
    chk("lit_first_fvalid", 64'(f_valid), 64'd1);
    chk("lit_first_fpc", f_pc, 64'h8000_0000);
    chk("lit_first_pc4", pcplus4, 64'h8000_0004);
    chk("lit_first_instr", 64'(f_raw_instr), 64'h13);

    // Stall for three cycles: everything frozen
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, '0, 1, 64'h8000_0004, 0, '0);
      chk("lit_stall_ireq", 64'(ireq_valid), 64'd0);
      chk("lit_stall_fpc", f_pc, 64'h8000_0000);
    end
    cycle(1, 0, '0, 0, 64'h8000_0004, 0, '0);
    chk("lit_pred_addr", ireq_addr, 64'h8000_0004);

    // Redirect before the response: old address held, data dropped
    cycle(1, 1, 64'h8000_1000, 0, '0, 0, '0);
    chk("lit_disc_addr", ireq_addr, 64'h8000_0004);
    chk("lit_disc_ireq", 64'(ireq_valid), 64'd1);
    cycle(1, 0, '0, 0, '0, 1, 32'hDEAD_BEEF);
    chk("lit_disc_next", ireq_addr, 64'h8000_1000);
    chk("lit_disc_fvalid", 64'(f_valid), 64'd0);

    // Redirect in the same cycle as the response
    cycle(1, 1, 64'h8000_2000, 0, '0, 1, 32'h1234_5678);
    chk("lit_same_addr", ireq_addr, 64'h8000_2000);
    chk("lit_same_fvalid", 64'(f_valid), 64'd0);

    // Redirect to a misaligned PC
    cycle(1, 1, 64'h8000_0002, 0, '0, 1, 32'hCAFE_F00D);
    chk("lit_mis_ireq", 64'(ireq_valid), 64'd0);
    cycle(1, 0, '0, 0, '0, 0, '0);
    chk("lit_mis_fvalid", 64'(f_valid), 64'd1);
    chk("lit_mis_exc", 64'(f_exc_misalign), 64'd1);
    chk("lit_mis_instr", 64'(f_raw_instr), 64'd0);
    chk("lit_mis_fpc", f_pc, 64'h8000_0002);

    // PC wrap for pcplus4
    cycle(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0, 0, '0);
    cycle(1, 0, '0, 0, '0, 1, 32'h0000_0013);
    chk("lit_wrap_fpc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("lit_wrap_pc4", pcplus4, 64'd0);

    // Reset in the middle of a request
    cycle(1, 0, '0, 0, 64'h8000_0040, 0, '0);
    chk("lit_mid_addr", ireq_addr, 64'h8000_0040);
    cycle(0, 0, '0, 0, '0, 0, '0);
    chk("lit_mid_rst_ireq", 64'(ireq_valid), 64'd0);
    cycle(1, 0, '0, 0, '0, 0, '0);
    chk("lit_mid_rst_addr", ireq_addr, RST);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit          r, rv, st, ok;
      logic [63:0] rpc, pp;
      logic [31:0] d;
      r   = ($urandom_range(0, 99) != 0);
      rv  = ($urandom_range(0, 99) < 12);
      rpc = rand_pc();
      st  = ($urandom_range(0, 99) < 40);
      pp  = ($urandom_range(0, 3) == 0) ? rand_pc() : m_fpc + 64'd4;
      ok  = r && exp_ireq(1'b1) && ($urandom_range(0, 2) == 0);
      d   = $urandom;
      cycle(r, rv, rpc, st, pp, ok, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcreg_fetch.md
Name: pcreg_fetch

Overview:
- PC register and instruction-fetch sequencer at the head of the fetch stage.
- Holds the architectural fetch PC and issues one request at a time on the instruction bus.
- Presents the returned instruction, its PC and PC+4 to the fetch/decode boundary.
- The sibling prediction block uses these outputs to compute pred_pc, which this block loads as the next PC. Execute-stage redirects override the prediction.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
pred_pc  in  64  predicted next PC from the fetch-stage predictor (combinational from f_pc/pcplus4)
redirect_valid  in  1  execute-stage redirect (mispredict/jump resolve)
redirect_pc  in  64  redirect target
stall  in  1  downstream cannot accept the presented instruction this cycle
ireq_valid  out  1  instruction bus request valid
ireq_addr  out  64  instruction bus request address
iresp_data_ok  in  1  response returned this cycle; completes the request
iresp_data  in  32  instruction word, valid with iresp_data_ok
f_valid  out  1  instruction presented to decode
f_pc  out  64  PC of presented instruction
f_raw_instr  out  32  presented instruction word
f_exc_misalign  out  1  presented PC is not 4-byte aligned
pcplus4  out  64  f_pc + 4, modulo 2^64 (wraps)

Behaviour:
- State register values: FETCH, VALID, DISCARD.
- Registers: pc (next PC to fetch), req_addr (address of the outstanding request), f_pc, f_raw_instr, f_exc_misalign.
- Reset (reset==0 at clock edge):
  - pc = req_addr = RESET_PC; state = FETCH.
  - f_pc = RESET_PC; f_raw_instr = 0; f_exc_misalign = 0.
  - While reset is low, ireq_valid = 0 and f_valid = 0.
  - Reset asserted mid-request abandons the request with no discard tracking; the bus is also reset.
- Bus rule:
  - ireq_valid stays high and ireq_addr stays stable from assertion until the cycle iresp_data_ok = 1 (inclusive).
  - ireq_addr = req_addr, never pc directly.
- FETCH:
  - ireq_valid = 1 when pc[1:0] == 0; f_valid = 0.
  - If pc[1:0] != 0: no bus request. Next state VALID with f_pc = pc, f_raw_instr = 0, f_exc_misalign = 1. A redirect in the same cycle wins: pc = redirect_pc, stay FETCH.
  - If iresp_data_ok and no redirect: f_pc = req_addr, f_raw_instr = iresp_data, f_exc_misalign = 0; next state VALID.
  - If iresp_data_ok and redirect: data dropped; pc = req_addr = redirect_pc; stay FETCH.
  - If redirect without data_ok: pc = redirect_pc; next state DISCARD (req_addr unchanged).
  - On entry to FETCH, req_addr is loaded with the new pc. Latency from FETCH entry to f_valid is at least 1 cycle after data_ok (registered).
- VALID:
  - f_valid = 1; ireq_valid = 0.
  - If redirect: pc = req_addr = redirect_pc; next state FETCH. Redirect has priority over stall.
  - Else if !stall: pc = req_addr = pred_pc; next state FETCH.
  - Else hold all outputs unchanged.
- DISCARD:
  - ireq_valid = 1 with the old req_addr; f_valid = 0.
  - Further redirects overwrite pc (latest wins).
  - On iresp_data_ok: data dropped; req_addr = pc (or redirect_pc if a redirect arrives in the same cycle); next state FETCH.
- Throughput: at most one instruction in flight; no f_valid while a request is outstanding.
- pcplus4 is combinational from f_pc.

Decomposition:
- pipes package:
  - fetch_state_t enum {FETCH, VALID, DISCARD}.
  - fetch_data_t struct {valid, pc[63:0], raw_instr[31:0], exc_misalign}, used for the f_* bundle at the fetch/decode register.
- common package: PC_RESET constant backing the RESET_PC default.
- No sub-module: a single FSM with datapath registers. The predictor is instantiated alongside in the fetch top, not inside this block.

Test Plan:
- Reset release, data_ok on cycle 3 with 32'h0000_0013 -> ireq_addr = 8000_0000 from cycle 1; f_valid = 1, f_pc = 8000_0000, pcplus4 = 8000_0004 on the following cycle.
- VALID with stall = 1 for 3 cycles, pred_pc = 8000_0004 -> outputs frozen, ireq_valid = 0. After stall drops, next ireq_addr = 8000_0004.
- Redirect to 8000_1000 one cycle before data_ok of the request at 8000_0004 -> ireq_addr stays 8000_0004 until data_ok; returned data never presented; next request 8000_1000.
- Redirect to 8000_2000 in the same cycle as data_ok -> data dropped; next ireq_addr = 8000_2000; f_valid stays 0.
- Redirect to 8000_0002 -> no bus request; f_valid = 1, f_exc_misalign = 1, f_raw_instr = 0, f_pc = 8000_0002.
- f_pc = FFFF_FFFF_FFFF_FFFC -> pcplus4 = 0. Also: reset driven low mid-request -> ireq_valid = 0 next cycle, pc = 8000_0000.
